// File: rtl/door_plant.sv
// Motorised door plant: integrates motor_up/motor_dn into a saturating position and drives the end-stop limit switches.
// Optional obstacle sensing while lowering is compiled in with `define DOOR_PLANT_OBSTACLE_EN.
module door_plant #(
  parameter int TRAVEL   = 8,
  parameter int STEP_DIV = 4,
  parameter int INIT_POS = 0,
  parameter int POS_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             motor_up,
  input  logic             motor_dn,
`ifdef DOOR_PLANT_OBSTACLE_EN
  input  logic             obstacle,
  output logic             obstructed,
`endif
  output logic             up_limit,
  output logic             dn_limit,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             stall,
  output logic             fault
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [POS_W-1:0] TRAVEL_P = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] INIT_P   = POS_W'(INIT_POS);
  localparam logic [POS_W-1:0] ZERO_P   = '0;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RAISING, S_LOWERING, S_FAULT} state_t;

  state_t           r_state, w_state_next;
  logic [POS_W-1:0] r_pos, w_pos_next;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic             w_step, w_hold, w_moving_next;
  logic             r_up_limit, r_dn_limit, r_moving, r_stall, r_fault;
`ifdef DOOR_PLANT_OBSTACLE_EN
  logic             r_obstructed;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (motor_up && motor_dn) w_state_next = S_FAULT;
        else if (motor_up)        w_state_next = S_RAISING;
        else if (motor_dn)        w_state_next = S_LOWERING;
      end
      S_RAISING: begin
        if (motor_up && motor_dn) w_state_next = S_FAULT;
        else if (motor_dn)        w_state_next = S_LOWERING;
        else if (!motor_up)       w_state_next = S_IDLE;
      end
      S_LOWERING: begin
        if (motor_up && motor_dn) w_state_next = S_FAULT;
        else if (motor_up)        w_state_next = S_RAISING;
        else if (!motor_dn)       w_state_next = S_IDLE;
      end
      S_FAULT: begin
        if (!motor_up && !motor_dn) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Obstacle freezes the step divider only while lowering continues.
`ifdef DOOR_PLANT_OBSTACLE_EN
  assign w_hold = obstacle && (r_state == S_LOWERING) && (w_state_next == S_LOWERING);
`else
  assign w_hold = 1'b0;
`endif

  assign w_moving_next = (w_state_next == S_RAISING) || (w_state_next == S_LOWERING);

  always_comb begin
    w_div_next = '0;
    w_step     = 1'b0;
    if ((w_state_next == r_state) && w_moving_next) begin
      if (w_hold) begin
        w_div_next = r_div;
      end else if (r_div == DIV_LAST) begin
        w_step = 1'b1;
      end else begin
        w_div_next = r_div + DIV_W'(1);
      end
    end
  end

  always_comb begin
    w_pos_next = r_pos;
    if (w_step && (r_state == S_RAISING) && (r_pos != TRAVEL_P))
      w_pos_next = r_pos + POS_W'(1);
    else if (w_step && (r_state == S_LOWERING) && (r_pos != ZERO_P))
      w_pos_next = r_pos - POS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pos      <= INIT_P;
      r_div      <= '0;
      r_moving   <= 1'b0;
      r_stall    <= 1'b0;
      r_fault    <= 1'b0;
      r_up_limit <= (INIT_P == TRAVEL_P);
      r_dn_limit <= (INIT_P == ZERO_P);
`ifdef DOOR_PLANT_OBSTACLE_EN
      r_obstructed <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_pos      <= w_pos_next;
      r_div      <= w_div_next;
      r_moving   <= w_moving_next;
      r_stall    <= ((w_state_next == S_RAISING) && (w_pos_next == TRAVEL_P)) ||
                    ((w_state_next == S_LOWERING) && (w_pos_next == ZERO_P));
      r_fault    <= (w_state_next == S_FAULT);
      r_up_limit <= (w_pos_next == TRAVEL_P);
      r_dn_limit <= (w_pos_next == ZERO_P);
`ifdef DOOR_PLANT_OBSTACLE_EN
      r_obstructed <= w_hold;
`endif
    end
  end

  assign pos      = r_pos;
  assign up_limit = r_up_limit;
  assign dn_limit = r_dn_limit;
  assign moving   = r_moving;
  assign stall    = r_stall;
  assign fault    = r_fault;
`ifdef DOOR_PLANT_OBSTACLE_EN
  assign obstructed = r_obstructed;
`endif

endmodule

// File: tb/tb_door_plant.sv
// Self-checking bench for door_plant: directed scenarios plus randomized commands against a cycle-count reference model.
// Two instances run in lockstep, one resetting to pos 0 and one to pos 5.
module tb_door_plant;

  localparam int TRAVEL   = 8;
  localparam int STEP_DIV = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RAISE = 1;
  localparam int M_LOWER = 2;
  localparam int M_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       motor_up = 1'b0;
  logic       motor_dn = 1'b0;
  logic       up_limit0, dn_limit0, moving0, stall0, fault0;
  logic       up_limit5, dn_limit5, moving5, stall5, fault5;
  logic [7:0] pos0, pos5;
`ifdef DOOR_PLANT_OBSTACLE_EN
  logic       obstacle = 1'b0;
  logic       obstructed0, obstructed5;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_pos[2];
  int m_mode[2];
  int m_run[2];
  int m_obs[2];
  int m_init[2] = '{0, 5};

  always #5 clk = ~clk;

  door_plant #(.TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV), .INIT_POS(0), .POS_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn),
`ifdef DOOR_PLANT_OBSTACLE_EN
    .obstacle(obstacle), .obstructed(obstructed0),
`endif
    .up_limit(up_limit0), .dn_limit(dn_limit0), .pos(pos0),
    .moving(moving0), .stall(stall0), .fault(fault0)
  );

  door_plant #(.TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV), .INIT_POS(5), .POS_W(8)) u_dut5 (
    .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn),
`ifdef DOOR_PLANT_OBSTACLE_EN
    .obstacle(obstacle), .obstructed(obstructed5),
`endif
    .up_limit(up_limit5), .dn_limit(dn_limit5), .pos(pos5),
    .moving(moving5), .stall(stall5), .fault(fault5)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a door moves one position every STEP_DIV cycles spent continuously in the same direction.
  task automatic model_update();
    int nm;
    bit blocked;
    for (int k = 0; k < 2; k++) begin
      m_obs[k] = 0;
      if (rst) begin
        m_mode[k] = M_IDLE;
        m_pos[k]  = m_init[k];
        m_run[k]  = 0;
      end else begin
        if (motor_up && motor_dn)   nm = M_FAULT;
        else if (m_mode[k] == M_FAULT) nm = (!motor_up && !motor_dn) ? M_IDLE : M_FAULT;
        else if (motor_up)          nm = M_RAISE;
        else if (motor_dn)          nm = M_LOWER;
        else                        nm = M_IDLE;
        if (nm != m_mode[k]) begin
          m_run[k] = 0;
        end else if (nm == M_RAISE || nm == M_LOWER) begin
          blocked = 1'b0;
`ifdef DOOR_PLANT_OBSTACLE_EN
          blocked = obstacle && (nm == M_LOWER);
          m_obs[k] = blocked ? 1 : 0;
`endif
          if (!blocked) begin
            m_run[k]++;
            if (m_run[k] % STEP_DIV == 0) begin
              if (nm == M_RAISE && m_pos[k] < TRAVEL) m_pos[k]++;
              if (nm == M_LOWER && m_pos[k] > 0)      m_pos[k]--;
            end
          end
        end
        m_mode[k] = nm;
      end
    end
  endtask

  task automatic check_dut(input int k, input int p, input logic ul, input logic dl,
                           input logic mv, input logic st, input logic ft);
    bit moving_exp;
    moving_exp = (m_mode[k] == M_RAISE) || (m_mode[k] == M_LOWER);
    chk($sformatf("pos%0d", k), p, m_pos[k]);
    chk($sformatf("up_limit%0d", k), int'(ul), int'(m_pos[k] == TRAVEL));
    chk($sformatf("dn_limit%0d", k), int'(dl), int'(m_pos[k] == 0));
    chk($sformatf("moving%0d", k), int'(mv), int'(moving_exp));
    chk($sformatf("stall%0d", k), int'(st),
        int'((m_mode[k] == M_RAISE && m_pos[k] == TRAVEL) || (m_mode[k] == M_LOWER && m_pos[k] == 0)));
    chk($sformatf("fault%0d", k), int'(ft), int'(m_mode[k] == M_FAULT));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_dut(0, int'(pos0), up_limit0, dn_limit0, moving0, stall0, fault0);
    check_dut(1, int'(pos5), up_limit5, dn_limit5, moving5, stall5, fault5);
`ifdef DOOR_PLANT_OBSTACLE_EN
    chk("obstructed0", int'(obstructed0), m_obs[0]);
    chk("obstructed5", int'(obstructed5), m_obs[1]);
`endif
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    motor_up = 1'b0;
    motor_dn = 1'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    int len;
    int r;

    do_reset();
    chk("rst_pos", int'(pos0), 0);
    chk("rst_dn_limit", int'(dn_limit0), 1);
    chk("rst_up_limit", int'(up_limit0), 0);
    chk("rst_moving", int'(moving0), 0);
    chk("rst_stall", int'(stall0), 0);
    chk("rst_fault", int'(fault0), 0);
    chk("rst_pos5", int'(pos5), 5);
    $display("reset: pos0=%0d pos5=%0d", pos0, pos5);

    motor_up = 1'b1;
    cycle();
    chk("raise_moving", int'(moving0), 1);
    for (int j = 1; j <= 32; j++) begin
      cycle();
      if (j % 4 == 3) chk("raise_hold", int'(pos0), j / 4);
      if (j % 4 == 0) chk("raise_step", int'(pos0), j / 4);
      if (j == 4) chk("raise_dn_limit", int'(dn_limit0), 0);
    end
    chk("raise_top", int'(pos0), 8);
    chk("raise_up_limit", int'(up_limit0), 1);
    cycles(3);
    chk("raise_stall", int'(stall0), 1);
    chk("raise_stall_moving", int'(moving0), 1);
    motor_up = 1'b0;
    cycle();
    chk("raise_idle_moving", int'(moving0), 0);
    chk("raise_idle_stall", int'(stall0), 0);
    $display("full raise: pos0=%0d up_limit=%0d", pos0, up_limit0);

    do_reset();
    motor_up = 1'b1;
    cycles(13);
    chk("fault_pre_pos", int'(pos0), 3);
    motor_dn = 1'b1;
    cycle();
    chk("fault_set", int'(fault0), 1);
    chk("fault_pos", int'(pos0), 3);
    motor_dn = 1'b0;
    cycles(5);
    chk("fault_hold", int'(fault0), 1);
    chk("fault_frozen", int'(pos0), 3);
    motor_up = 1'b0;
    cycle();
    chk("fault_clear", int'(fault0), 0);
    chk("fault_idle", int'(moving0), 0);
    $display("fault: pos0=%0d fault=%0d", pos0, fault0);

    do_reset();
    motor_up = 1'b1;
    cycles(11);
    chk("rev_pos2", int'(pos0), 2);
    motor_up = 1'b0;
    motor_dn = 1'b1;
    cycles(4);
    chk("rev_no_early_step", int'(pos0), 2);
    cycle();
    chk("rev_pos1", int'(pos0), 1);
    cycles(4);
    chk("rev_pos0", int'(pos0), 0);
    chk("rev_dn_limit", int'(dn_limit0), 1);
    $display("reversal: pos0=%0d dn_limit=%0d", pos0, dn_limit0);

    do_reset();
    motor_dn = 1'b1;
    cycles(9);
    chk("mid_pos3", int'(pos5), 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    motor_dn = 1'b0;
    chk("mid_rst_pos", int'(pos5), 5);
    chk("mid_rst_moving", int'(moving5), 0);
    chk("mid_rst_up_limit", int'(up_limit5), 0);
    chk("mid_rst_dn_limit", int'(dn_limit5), 0);
    $display("reset mid-travel: pos5=%0d", pos5);

`ifdef DOOR_PLANT_OBSTACLE_EN
    do_reset();
    motor_up = 1'b1;
    cycles(25);
    chk("obs_pre_pos", int'(pos0), 6);
    motor_up = 1'b0;
    motor_dn = 1'b1;
    cycles(3);
    obstacle = 1'b1;
    cycles(12);
    chk("obs_frozen", int'(pos0), 6);
    chk("obs_flag", int'(obstructed0), 1);
    obstacle = 1'b0;
    cycle();
    chk("obs_release", int'(obstructed0), 0);
    cycles(30);
    chk("obs_bottom", int'(pos0), 0);
    $display("obstacle: pos0=%0d", pos0);
`endif

    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      r = int'($urandom_range(0, 99));
      motor_up = (r < 40) || (r >= 90);
      motor_dn = (r >= 40 && r < 75) || (r >= 90);
      rst = ($urandom_range(0, 29) == 0);
`ifdef DOOR_PLANT_OBSTACLE_EN
      obstacle = ($urandom_range(0, 4) == 0);
`endif
      len = int'($urandom_range(1, 40));
      cycle();
      rst = 1'b0;
      cycles(len - 1);
      $display("seg %0d: up=%0d dn=%0d len=%0d pos0=%0d pos5=%0d", seg, motor_up, motor_dn, len, pos0, pos5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
